// File: rtl/cby_cfg_param_pkg.sv
// Shared types and elaboration-time helpers for the parametrised Y-channel connection block.
package cby_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    FULL    = 2'd2,
    ACTIVE  = 2'd3
  } cfg_state_e;

  // Smallest r with 2**r >= n.
  function automatic int clog2(input int n);
    int r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Track feeding candidate k of pin p: candidates come in bottom/top pairs spaced by stride.
  function automatic int track_idx(input int p, input int k, input int stride, input int chan_w);
    return ((k >> 1) * stride + p) % chan_w;
  endfunction

endpackage

// File: rtl/cby_cfg_param_if.sv
// Channel, configuration-chain and pin bundle of one CBY tile.
interface cby_cfg_param_if #(
  parameter int CHAN_W   = 20,
  parameter int NUM_PINS = 16
);
  logic [CHAN_W-1:0]   chany_bottom_in;
  logic [CHAN_W-1:0]   chany_top_in;
  logic [CHAN_W-1:0]   chany_bottom_out;
  logic [CHAN_W-1:0]   chany_top_out;
  logic                ccff_head;
  logic                cfg_en;
  logic                cfg_commit;
  logic                ccff_tail;
  logic                cfg_done;
  logic                cfg_err;
  logic [NUM_PINS-1:0] left_grid_pin;

  modport master (
    output chany_bottom_in, chany_top_in, ccff_head, cfg_en, cfg_commit,
    input  chany_bottom_out, chany_top_out, ccff_tail, cfg_done, cfg_err, left_grid_pin
  );

  modport slave (
    input  chany_bottom_in, chany_top_in, ccff_head, cfg_en, cfg_commit,
    output chany_bottom_out, chany_top_out, ccff_tail, cfg_done, cfg_err, left_grid_pin
  );
endinterface

// File: rtl/cby_cfg_param_mux.sv
// One grid-pin mux: selects one of MUX_SIZE candidates; an out-of-range select drives 0.
module cby_cfg_mux #(
  parameter int MUX_SIZE = 10,
  parameter int SEL_W    = 4
) (
  input  logic [MUX_SIZE-1:0] cand,
  input  logic [SEL_W-1:0]    sel,
  output logic                pin
);

  always_comb begin
    // NOTE: default first, so every path assigns pin and no latch is inferred.
    pin = 1'b0;
    if (int'(sel) < MUX_SIZE) pin = cand[sel];
  end

endmodule

// File: rtl/cby_cfg_param.sv
// Parametrised CBY tile with shadow/active configuration registers and explicit commit.
// Define CBY_CFG_PARITY_EN to append an even-parity bit to the chain and reject bad images.
module cby_cfg_param
  import cby_cfg_pkg::*;
#(
  parameter int CHAN_W       = 20,
  parameter int NUM_PINS     = 16,
  parameter int MUX_SIZE     = 10,
  parameter int TRACK_STRIDE = 3
) (
  input logic            prog_clk,
  input logic            prog_reset,
  cby_cfg_param_if.slave bus
);

  localparam int SEL_W = clog2(MUX_SIZE);
  localparam int IMG_W = NUM_PINS * SEL_W;
`ifdef CBY_CFG_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int CFG_LEN = IMG_W + PAR_W;
  localparam int CNT_W   = clog2(CFG_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_LEN);

  cfg_state_e          state, state_next;
  logic [CNT_W-1:0]    count, count_next;
  logic [CFG_LEN-1:0]  shadow;
  logic [IMG_W-1:0]    active;
  logic                cfg_done, cfg_err;
  logic                parity_ok, accept;
  logic [NUM_PINS-1:0] pins;

`ifdef CBY_CFG_PARITY_EN
  assign parity_ok = ~^shadow;
`else
  assign parity_ok = 1'b1;
`endif

  assign accept = bus.cfg_commit && (state == FULL) && parity_ok;

  // A commit zeroes the counter; a simultaneous shift then counts from there.
  always_comb begin
    state_next = state;
    count_next = count;
    if (bus.cfg_en) begin
      if (accept) count_next = CNT_W'(1);
      else if (count != CNT_MAX) count_next = count + 1'b1;
      state_next = (count_next == CNT_MAX) ? FULL : LOADING;
    end else if (accept) begin
      count_next = '0;
      state_next = ACTIVE;
    end
  end

  // NOTE: registers update with <= so every block samples pre-edge values.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state    <= IDLE;
      count    <= '0;
      shadow   <= '0;
      active   <= '0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (bus.cfg_en) shadow <= {shadow[CFG_LEN-2:0], bus.ccff_head};
      if (accept) begin
        active   <= shadow[CFG_LEN-1 -: IMG_W];
        cfg_done <= 1'b1;
      end
      if (bus.cfg_commit && !accept) cfg_err <= 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
    logic [MUX_SIZE-1:0] cand;
    for (genvar k = 0; k < MUX_SIZE; k++) begin : g_cand
      localparam int T = track_idx(p, k, TRACK_STRIDE, CHAN_W);
      if (k % 2 == 0) begin : g_bot
        assign cand[k] = bus.chany_bottom_in[T];
      end else begin : g_top
        assign cand[k] = bus.chany_top_in[T];
      end
    end
    cby_cfg_mux #(.MUX_SIZE(MUX_SIZE), .SEL_W(SEL_W)) u_mux (
      .cand (cand),
      .sel  (active[p*SEL_W +: SEL_W]),
      .pin  (pins[p])
    );
  end

  assign bus.left_grid_pin    = pins;
  assign bus.chany_bottom_out = bus.chany_top_in;
  assign bus.chany_top_out    = bus.chany_bottom_in;
  assign bus.ccff_tail        = shadow[CFG_LEN-1];
  assign bus.cfg_done         = cfg_done;
  assign bus.cfg_err          = cfg_err;

endmodule
